// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory.
//   - imem_state_e : controller state (clearing the array / serving fetches)
//   - WORD_BYTES   : bytes per instruction word
//   - IMEM_NOP_WORD: default NOP encoding, shared with the decoder
//   - clog2        : ceiling log2 for sizing index fields
package imem_pkg;

    typedef enum logic {
        IMEM_CLEAR = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

    // Ceiling log2; value is expected to be >= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((64'(value) - 64'd1) >> i) != 64'd0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Byte address to word index translation with fault detection.
//   addr    : byte address presented by a port
//   idx_c   : word index (offset from BASE_ADDR, divided by 4)
//   fault_c : misaligned, or outside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0]               addr,
    output logic [clog2(DEPTH)-1:0]   idx_c,
    output logic                      fault_c
);

    localparam int unsigned AW   = clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(WORD_BYTES * DEPTH);

    logic [31:0] off;

    // Wrapping subtract: addresses below BASE_ADDR become huge offsets and fail the range test.
    always_comb begin
        off     = addr - BASE_ADDR;
        idx_c   = off[AW+1:2];
        fault_c = (off[1:0] != 2'b00) || (off >= SPAN);
    end

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with run-time programming port.
// After reset the array is filled with NOP_WORD, one word per cycle; ready
// then rises and fetches return the addressed word one cycle after request.
//   clk, reset                   : clock, synchronous active-high reset
//   ready                        : clear sequence finished
//   fetch_req/fetch_addr/stall   : IF-stage fetch request and pipeline hold
//   fetch_valid/instruction/addr_fault : registered fetch response
//   prog_we/prog_addr/prog_data  : programming write port
//   prog_err                     : one-cycle pulse when a write is dropped
module imem_sync
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = IMEM_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [31:0] instruction,
    output logic        addr_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        prog_err
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [31:0] mem [0:DEPTH-1];

    imem_state_e   state, state_nxt;
    logic [AW-1:0] cnt;

    logic [AW-1:0] fidx, pidx;
    logic          ffault, pfault;

    logic          mem_we_c;
    logic [AW-1:0] mem_widx_c;
    logic [31:0]   mem_wdata_c;
    logic          prog_err_c;
    logic          fetch_upd_c;
    logic          fetch_valid_c;
    logic          fetch_fault_c;
    logic          wr_hit_c;

    imem_addr_check #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_fetch_chk (
        .addr    (fetch_addr),
        .idx_c   (fidx),
        .fault_c (ffault)
    );

    imem_addr_check #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_prog_chk (
        .addr    (prog_addr),
        .idx_c   (pidx),
        .fault_c (pfault)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IMEM_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR once the last word is written.
    always_comb begin
        state_nxt = state;
        if (state == IMEM_CLEAR && cnt == AW'(DEPTH - 1)) begin
            state_nxt = IMEM_READY;
        end
    end

    // Per-state write port selection and fetch response decode.
    always_comb begin
        mem_we_c      = 1'b0;
        mem_widx_c    = '0;
        mem_wdata_c   = NOP_WORD;
        prog_err_c    = 1'b0;
        fetch_upd_c   = 1'b0;
        fetch_valid_c = 1'b0;
        fetch_fault_c = 1'b0;
        wr_hit_c      = 1'b0;
        case (state)
            IMEM_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_widx_c  = cnt;
                prog_err_c  = prog_we;
                fetch_upd_c = 1'b1;
            end
            IMEM_READY: begin
                mem_we_c      = prog_we && !pfault;
                mem_widx_c    = pidx;
                mem_wdata_c   = prog_data;
                prog_err_c    = prog_we && pfault;
                fetch_upd_c   = !stall;
                fetch_valid_c = fetch_req;
                fetch_fault_c = fetch_req && ffault;
                wr_hit_c      = mem_we_c && (pidx == fidx);
            end
        endcase
    end

    // Array write port; contents are initialised by the clear sequence, not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
    end

    // Registered outputs, clear counter and fetch read (write-first on index collision).
    always_ff @(posedge clk) begin
        if (reset) begin
            ready       <= 1'b0;
            prog_err    <= 1'b0;
            cnt         <= '0;
            fetch_valid <= 1'b0;
            addr_fault  <= 1'b0;
            instruction <= NOP_WORD;
        end else begin
            ready    <= (state_nxt == IMEM_READY);
            prog_err <= prog_err_c;
            if (state == IMEM_CLEAR) begin
                cnt <= cnt + AW'(1);
            end
            if (fetch_upd_c) begin
                fetch_valid <= fetch_valid_c;
                addr_fault  <= fetch_fault_c;
                if (!fetch_valid_c || fetch_fault_c) begin
                    instruction <= NOP_WORD;
                end else if (wr_hit_c) begin
                    instruction <= prog_data;
                end else begin
                    instruction <= mem[fidx];
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_imem_sync;

    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic        addr_fault;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_err;

    int total = 0;
    int bad   = 0;

    imem_sync #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .fetch_valid (fetch_valid),
        .instruction (instruction),
        .addr_fault  (addr_fault),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_err    (prog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) begin
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [0:DEPTH-1];
    int unsigned m_clear_cycles = 0;
    logic        m_ready = 1'b0;
    logic        m_fv = 1'b0;
    logic [31:0] m_ins = NOP;
    logic        m_af = 1'b0;
    logic        m_perr = 1'b0;
    logic        chk_en = 1'b0;
    logic [31:0] m_poff, m_foff;
    logic        m_pbad, m_fbad;

    always @(posedge clk) begin
        if (reset) begin
            m_clear_cycles = 0;
            m_ready = 1'b0;
            m_fv    = 1'b0;
            m_ins   = NOP;
            m_af    = 1'b0;
            m_perr  = 1'b0;
            chk_en  = 1'b1;
        end else if (m_clear_cycles < DEPTH) begin
            m_clear_cycles++;
            m_perr = prog_we;
            m_fv   = 1'b0;
            m_ins  = NOP;
            m_af   = 1'b0;
            if (m_clear_cycles == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
                m_ready = 1'b1;
            end
        end else begin
            m_poff = prog_addr - BASE_ADDR;
            m_pbad = (m_poff % 4 != 0) || (m_poff >= 4 * DEPTH);
            m_perr = prog_we && m_pbad;
            if (prog_we && !m_pbad) m_mem[m_poff / 4] = prog_data;
            if (!stall) begin
                if (fetch_req) begin
                    m_foff = fetch_addr - BASE_ADDR;
                    m_fbad = (m_foff % 4 != 0) || (m_foff >= 4 * DEPTH);
                    m_fv   = 1'b1;
                    m_af   = m_fbad;
                    m_ins  = m_fbad ? NOP : m_mem[m_foff / 4];
                end else begin
                    m_fv  = 1'b0;
                    m_ins = NOP;
                    m_af  = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",       32'(ready),       32'(m_ready));
            check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            check("instruction", instruction,      m_ins);
            check("addr_fault",  32'(addr_fault),  32'(m_af));
            check("prog_err",    32'(prog_err),    32'(m_perr));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        fetch_req = 1'b0;
        stall     = 1'b0;
        prog_we   = 1'b0;
    endtask

    // Release reset and walk the clear sequence, pinning the ready edge.
    task automatic run_clear(input string tag);
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) check({tag, "_ready_low"}, 32'(ready), 32'd0);
            if (i == DEPTH)     check({tag, "_ready_high"}, 32'(ready), 32'd1);
        end
    endtask

    task automatic random_phase(input int cycles);
        int r;
        for (int c = 0; c < cycles; c++) begin
            stall     = ($urandom_range(0, 4) == 0);
            fetch_req = ($urandom_range(0, 3) != 0);
            prog_we   = ($urandom_range(0, 2) == 0);
            prog_data = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       fetch_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            else if (r == 7) fetch_addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (r == 8) fetch_addr = $urandom;
            else             fetch_addr = (c % 2 == 0) ? 32'h0000_03FC : 32'hFFFF_FFFC;
            r = $urandom_range(0, 9);
            if (r < 8)       prog_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            else if (r == 8) prog_addr = 32'h0000_0400;
            else             prog_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b10};
            if ($urandom_range(0, 5) == 0) prog_addr = fetch_addr;
            tick();
        end
        idle();
    endtask

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        stall      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 32'h0;
        prog_data  = 32'h0;
        tick();
        tick();
        check("reset_ready",       32'(ready),       32'd0);
        check("reset_fetch_valid", 32'(fetch_valid), 32'd0);
        check("reset_instruction", instruction,      NOP);
        check("reset_prog_err",    32'(prog_err),    32'd0);

        // Clear sequence, with a dropped write and an ignored fetch mid-clear
        reset = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'hDEAD_BEEF;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        check("clear_prog_err",    32'(prog_err),    32'd1);
        check("clear_fetch_valid", 32'(fetch_valid), 32'd0);
        idle();
        for (int i = 3; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) check("init_ready_low", 32'(ready), 32'd0);
            if (i == DEPTH)     check("init_ready_high", 32'(ready), 32'd1);
        end

        // Fetch cleared words
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        check("f0_valid", 32'(fetch_valid), 32'd1);
        check("f0_ins",   instruction,      32'h0);
        check("f0_fault", 32'(addr_fault),  32'd0);
        fetch_addr = 32'h3FC;
        tick();
        check("f3fc_ins",   instruction,     32'h0);
        check("f3fc_fault", 32'(addr_fault), 32'd0);

        // Program two words then fetch them back-to-back
        fetch_req = 1'b0;
        prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'h2004_0003;
        tick();
        prog_addr = 32'h4; prog_data = 32'h0C10_0005;
        tick();
        prog_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        check("prog0_ins", instruction, 32'h2004_0003);
        fetch_addr = 32'h4;
        tick();
        check("prog4_ins", instruction, 32'h0C10_0005);

        // Stall holds the response while the address changes
        stall = 1'b1; fetch_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ins",   instruction,      32'h0C10_0005);
            check("stall_valid", 32'(fetch_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        check("unstall_ins", instruction, 32'h2004_0003);

        // Faulting fetches and a dropped write
        fetch_addr = 32'h402;
        tick();
        check("f402_fault", 32'(addr_fault), 32'd1);
        check("f402_ins",   instruction,     NOP);
        fetch_addr = 32'h400;
        tick();
        check("f400_fault", 32'(addr_fault), 32'd1);
        check("f400_valid", 32'(fetch_valid), 32'd1);
        fetch_req = 1'b0;
        prog_we = 1'b1; prog_addr = 32'h400; prog_data = 32'hCAFE_F00D;
        tick();
        check("p400_err", 32'(prog_err), 32'd1);
        prog_we = 1'b0;
        tick();
        check("p400_err_pulse", 32'(prog_err), 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        check("mem0_kept", instruction, 32'h2004_0003);

        // Same-cycle write and fetch to one index
        prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'h1000_FFFF;
        fetch_addr = 32'h8;
        tick();
        check("wfirst_ins", instruction, 32'h1000_FFFF);
        idle();
        tick();

        random_phase(3000);

        // Reset mid-clear, then full clear wipes programmed words
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("midclear_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        tick();
        run_clear("reclear");
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        check("reclear_mem0", instruction, NOP);
        fetch_addr = 32'h8;
        tick();
        check("reclear_mem8", instruction, NOP);
        idle();

        random_phase(2000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
